// File: rtl/decode_stage.sv
// RV32I decode stage: register file with write bypass, immediate/control decode,
// load-use hazard unit and the ID/EX pipeline register. Optional DECODE_ILLEGAL_TRAP_EN.
module decode_stage #(
  parameter int unsigned REG_COUNT = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] nextinst,
  input  logic [31:0] nextPC,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ex_branch_taken,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IF_flush,
  output logic [31:0] idex_pc,
  output logic [31:0] idex_rs1_data,
  output logic [31:0] idex_rs2_data,
  output logic [31:0] idex_imm,
  output logic [4:0]  idex_rs1,
  output logic [4:0]  idex_rs2,
  output logic [4:0]  idex_rd,
  output logic [2:0]  idex_funct3,
  output logic        idex_funct7b5,
  output logic [9:0]  idex_ctrl,
  output logic        idex_illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // {reg_write, mem_read, mem_write, mem_to_reg, branch, jump, alu_src, pc_src_a, alu_op}
  localparam logic [9:0] CTRL_LOAD   = 10'b1101001000;
  localparam logic [9:0] CTRL_IMM    = 10'b1000001011;
  localparam logic [9:0] CTRL_AUIPC  = 10'b1000001100;
  localparam logic [9:0] CTRL_STORE  = 10'b0010001000;
  localparam logic [9:0] CTRL_REG    = 10'b1000000010;
  localparam logic [9:0] CTRL_LUI    = 10'b1000001000;
  localparam logic [9:0] CTRL_BRANCH = 10'b0000100001;
  localparam logic [9:0] CTRL_JALR   = 10'b1000011000;
  localparam logic [9:0] CTRL_JAL    = 10'b1000011100;
  localparam int unsigned MEM_READ_BIT = 8;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] regs [REG_COUNT];
  logic [31:0] rs1_data, rs2_data, imm;
  logic [9:0]  ctrl;
  logic        rs1_used, rs2_used, legal;
  logic        stall, flush, bubble;

  assign opcode = nextinst[6:0];
  assign rd     = nextinst[11:7];
  assign rs1    = nextinst[19:15];
  assign rs2    = nextinst[24:20];

  // Register file; x0 is never written
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Same-cycle writeback is forwarded so decode never sees a stale value
  always_comb begin
    rs1_data = regs[rs1];
    rs2_data = regs[rs2];
    if (wb_en && wb_rd == rs1) rs1_data = wb_data;
    if (wb_en && wb_rd == rs2) rs2_data = wb_data;
    if (rs1 == 5'd0) rs1_data = '0;
    if (rs2 == 5'd0) rs2_data = '0;
  end

  always_comb begin
    imm = '0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: imm = {{20{nextinst[31]}}, nextinst[31:20]};
      OP_STORE:  imm = {{20{nextinst[31]}}, nextinst[31:25], nextinst[11:7]};
      OP_BRANCH: imm = {{19{nextinst[31]}}, nextinst[31], nextinst[7],
                        nextinst[30:25], nextinst[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm = {nextinst[31:12], 12'b0};
      OP_JAL:    imm = {{11{nextinst[31]}}, nextinst[31], nextinst[19:12],
                        nextinst[20], nextinst[30:21], 1'b0};
      default:   imm = '0;
    endcase
  end

  always_comb begin
    ctrl     = '0;
    legal    = 1'b1;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      OP_LOAD:   ctrl = CTRL_LOAD;
      OP_IMM:    ctrl = CTRL_IMM;
      OP_JALR:   ctrl = CTRL_JALR;
      OP_STORE:  begin ctrl = CTRL_STORE;  rs2_used = 1'b1; end
      OP_REG:    begin ctrl = CTRL_REG;    rs2_used = 1'b1; end
      OP_BRANCH: begin ctrl = CTRL_BRANCH; rs2_used = 1'b1; end
      OP_LUI:    begin ctrl = CTRL_LUI;    rs1_used = 1'b0; end
      OP_AUIPC:  begin ctrl = CTRL_AUIPC;  rs1_used = 1'b0; end
      OP_JAL:    begin ctrl = CTRL_JAL;    rs1_used = 1'b0; end
      default:   legal = 1'b0;
    endcase
  end

  // Load-use hazard: the load in EX has not produced data for this instruction yet
  assign stall = idex_ctrl[MEM_READ_BIT] && idex_rd != 5'd0 &&
                 ((rs1_used && idex_rd == rs1) || (rs2_used && idex_rd == rs2));
  assign flush  = rst_n && ex_branch_taken;
  assign bubble = stall || flush;

  // A taken branch overrides the stall: the stalled instruction is squashed anyway
  assign PCWrite   = !rst_n || flush || !stall;
  assign IFIDWrite = !rst_n || flush || !stall;
  assign IF_flush  = flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_pc       <= '0;
      idex_rs1_data <= '0;
      idex_rs2_data <= '0;
      idex_imm      <= '0;
      idex_rs1      <= '0;
      idex_rs2      <= '0;
      idex_rd       <= '0;
      idex_funct3   <= '0;
      idex_funct7b5 <= 1'b0;
      idex_ctrl     <= '0;
    end else begin
      idex_pc       <= nextPC;
      idex_rs1_data <= rs1_data;
      idex_rs2_data <= rs2_data;
      idex_imm      <= imm;
      idex_rs1      <= rs1;
      idex_rs2      <= rs2;
      idex_rd       <= bubble ? NOP_INSTR[11:7] : rd;
      idex_funct3   <= nextinst[14:12];
      idex_funct7b5 <= nextinst[30];
      idex_ctrl     <= bubble ? 10'd0 : ctrl;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) idex_illegal <= 1'b0;
    else        idex_illegal <= !bubble && !legal;
  end
`else
  logic unused_legal;
  assign unused_legal = legal;
  assign idex_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: reset, bypass, load-use,
// flush priority, immediates and the illegal-opcode flag.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] nextinst, nextPC;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_branch_taken;
  logic        PCWrite, IFIDWrite, IF_flush;
  logic [31:0] idex_pc, idex_rs1_data, idex_rs2_data, idex_imm;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd;
  logic [2:0]  idex_funct3;
  logic        idex_funct7b5;
  logic [9:0]  idex_ctrl;
  logic        idex_illegal;

  int unsigned n_compared = 0;
  int unsigned n_mismatched = 0;

  localparam logic [9:0] C_IMM    = 10'h20B;
  localparam logic [9:0] C_REG    = 10'h202;
  localparam logic [9:0] C_LOAD   = 10'h348;
  localparam logic [9:0] C_STORE  = 10'h088;
  localparam logic [9:0] C_BRANCH = 10'h021;
  localparam logic [9:0] C_JAL    = 10'h21C;
  localparam logic [9:0] C_LUI    = 10'h208;
  localparam logic [9:0] C_AUIPC  = 10'h20C;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic ILLEGAL_EXP = 1'b1;
`else
  localparam logic ILLEGAL_EXP = 1'b0;
`endif

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .nextinst(nextinst), .nextPC(nextPC),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_branch_taken(ex_branch_taken),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IF_flush(IF_flush),
    .idex_pc(idex_pc), .idex_rs1_data(idex_rs1_data), .idex_rs2_data(idex_rs2_data),
    .idex_imm(idex_imm), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
    .idex_funct3(idex_funct3), .idex_funct7b5(idex_funct7b5),
    .idex_ctrl(idex_ctrl), .idex_illegal(idex_illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    nextinst = inst;
    nextPC   = pc;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; nextinst = 32'h00000013; nextPC = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; ex_branch_taken = 1'b1;
    #1;
    check_eq("rst_pcwrite", 32'(PCWrite), 32'd1);
    check_eq("rst_ifidwrite", 32'(IFIDWrite), 32'd1);
    check_eq("rst_if_flush", 32'(IF_flush), 32'd0);
    step(); step();
    ex_branch_taken = 1'b0;
    check_eq("rst_ctrl", 32'(idex_ctrl), 32'd0);
    check_eq("rst_pc", idex_pc, 32'd0);
    check_eq("rst_imm", idex_imm, 32'd0);
    check_eq("rst_rd", 32'(idex_rd), 32'd0);
    check_eq("rst_illegal", 32'(idex_illegal), 32'd0);

    // addi x1,x0,5
    rst_n = 1'b1;
    issue(32'h00500093, 32'h100);
    step();
    check_eq("addi_imm", idex_imm, 32'd5);
    check_eq("addi_rd", 32'(idex_rd), 32'd1);
    check_eq("addi_ctrl", 32'(idex_ctrl), 32'(C_IMM));
    check_eq("addi_pc", idex_pc, 32'h100);

    // add x4,x3,x3 with simultaneous writeback of x3
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    issue(32'h00318233, 32'h104);
    step();
    check_eq("byp_rs1", idex_rs1_data, 32'hDEADBEEF);
    check_eq("byp_rs2", idex_rs2_data, 32'hDEADBEEF);
    check_eq("byp_ctrl", 32'(idex_ctrl), 32'(C_REG));
    wb_en = 1'b0;
    issue(32'h00318233, 32'h108);
    step();
    check_eq("rf_rs1", idex_rs1_data, 32'hDEADBEEF);

    // write to x0 is ignored, with and without bypass
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h12345678;
    issue(32'h00000233, 32'h10C);
    step();
    check_eq("x0_byp", idex_rs1_data, 32'd0);
    wb_en = 1'b0;
    step();
    check_eq("x0_rf", idex_rs2_data, 32'd0);

    // lw x5,0(x1) then add x6,x5,x2 -> one bubble
    issue(32'h0000A283, 32'h110);
    step();
    check_eq("lw_ctrl", 32'(idex_ctrl), 32'(C_LOAD));
    check_eq("lw_rd", 32'(idex_rd), 32'd5);
    issue(32'h00228333, 32'h114);
    check_eq("lu_pcwrite", 32'(PCWrite), 32'd0);
    check_eq("lu_ifidwrite", 32'(IFIDWrite), 32'd0);
    check_eq("lu_if_flush", 32'(IF_flush), 32'd0);
    step();
    check_eq("lu_bubble", 32'(idex_ctrl), 32'd0);
    check_eq("lu_release", 32'(PCWrite), 32'd1);
    step();
    check_eq("lu_issue_ctrl", 32'(idex_ctrl), 32'(C_REG));
    check_eq("lu_issue_rd", 32'(idex_rd), 32'd6);

    // lw x0 then add x6,x0,x2 -> no stall
    issue(32'h0000A003, 32'h118);
    step();
    issue(32'h00200333, 32'h11C);
    check_eq("x0_nostall", 32'(PCWrite), 32'd1);
    check_eq("x0_nostall_ifid", 32'(IFIDWrite), 32'd1);
    step();
    check_eq("x0_ctrl", 32'(idex_ctrl), 32'(C_REG));

    // lw x5 then lui x5 -> no stall, U immediate
    issue(32'h0000A283, 32'h120);
    step();
    issue(32'h123452B7, 32'h124);
    check_eq("lui_nostall", 32'(PCWrite), 32'd1);
    step();
    check_eq("lui_ctrl", 32'(idex_ctrl), 32'(C_LUI));
    check_eq("lui_imm", idex_imm, 32'h12345000);

    // lw x5 then add x6,x2,x5 (rs2 hazard), with and without a coincident flush
    issue(32'h0000A283, 32'h128);
    step();
    issue(32'h00510333, 32'h12C);
    check_eq("rs2_stall", 32'(PCWrite), 32'd0);
    ex_branch_taken = 1'b1;
    #1;
    check_eq("fl_if_flush", 32'(IF_flush), 32'd1);
    check_eq("fl_pcwrite", 32'(PCWrite), 32'd1);
    check_eq("fl_ifidwrite", 32'(IFIDWrite), 32'd1);
    step();
    ex_branch_taken = 1'b0;
    check_eq("fl_bubble", 32'(idex_ctrl), 32'd0);

    // flush alone squashes a valid instruction
    issue(32'h00500093, 32'h200);
    ex_branch_taken = 1'b1;
    step();
    ex_branch_taken = 1'b0;
    check_eq("fl_only_ctrl", 32'(idex_ctrl), 32'd0);

    // beq x1,x2,-8
    issue(32'hFE208CE3, 32'h204);
    step();
    check_eq("beq_imm", idex_imm, 32'hFFFFFFF8);
    check_eq("beq_ctrl", 32'(idex_ctrl), 32'(C_BRANCH));

    // jal x1,2048
    issue(32'h001000EF, 32'h208);
    step();
    check_eq("jal_imm", idex_imm, 32'h00000800);
    check_eq("jal_ctrl", 32'(idex_ctrl), 32'(C_JAL));

    // sw x2,-4(x1)
    issue(32'hFE20AE23, 32'h20C);
    step();
    check_eq("sw_imm", idex_imm, 32'hFFFFFFFC);
    check_eq("sw_ctrl", 32'(idex_ctrl), 32'(C_STORE));
    check_eq("sw_funct3", 32'(idex_funct3), 32'd2);

    // auipc x7,1
    issue(32'h00001397, 32'h210);
    step();
    check_eq("auipc_imm", idex_imm, 32'h00001000);
    check_eq("auipc_ctrl", 32'(idex_ctrl), 32'(C_AUIPC));
    check_eq("auipc_pc", idex_pc, 32'h210);

    // unsupported opcode 1111111
    issue(32'h0000007F, 32'h214);
    step();
    check_eq("ill_ctrl", 32'(idex_ctrl), 32'd0);
    check_eq("ill_imm", idex_imm, 32'd0);
    check_eq("ill_flag", 32'(idex_illegal), 32'(ILLEGAL_EXP));
    issue(32'h00500093, 32'h218);
    step();
    check_eq("ill_clear", 32'(idex_illegal), 32'd0);
    check_eq("ill_next_ctrl", 32'(idex_ctrl), 32'(C_IMM));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
